// File: rtl/system_bus_pkg.sv
// Shared definitions for the serial system bus, used by the master output
// port and the slave input side: field widths and the port state encoding.
package system_bus_pkg;

    localparam int ADDR_W  = 12;  // serial address field width
    localparam int DATA_W  = 8;   // serial data field width
    localparam int BURST_W = 13;  // burst word: bit0 = burst flag, [12:1] = beat count

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_BEAT  = 3'd4,
        ST_DONE  = 3'd5
    } bus_state_t;

endpackage

// File: rtl/bus_piso.sv
// bus_piso: loadable parallel-in/serial-out shift register, LSB first.
// The current bit is always visible on dout; count tracks shifts since load.
module bus_piso #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          shift,
    input  logic [W-1:0]  din,
    output logic          dout,
    output logic [CW-1:0] count
);

    logic [W-1:0] sreg;

    // Load a new word or shift right, back-filling zeros past the field end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg  <= '0;
            count <= '0;
        end else if (load) begin
            sreg  <= din;
            count <= '0;
        end else if (shift) begin
            sreg  <= {1'b0, sreg[W-1:1]};
            count <= count + CW'(1);
        end
    end

    assign dout = sreg[0];

endmodule

// File: rtl/master_out_port.sv
// master_out_port: serial bus master. Accepts a local command, handshakes
// with the slave, then shifts address, data and burst word out LSB first.
// Optional write-burst beats are built only when MASTER_OUT_BURST_EN is defined.
module master_out_port #(
    parameter int ADDR_W  = system_bus_pkg::ADDR_W,
    parameter int DATA_W  = system_bus_pkg::DATA_W,
    parameter int BURST_W = system_bus_pkg::BURST_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic               cmd_wr,
    input  logic [BURST_W-2:0] cmd_len,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               wdata_valid,
    output logic               wdata_ready,
    input  logic               slave_ready,
    output logic               master_valid,
    output logic               read_en,
    output logic               write_en,
    output logic               tx_address,
    output logic               tx_data,
    output logic               tx_burst,
    output logic               tx_done
);
    import system_bus_pkg::*;

    localparam int CNT_W = $clog2(BURST_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);

    bus_state_t        state;
    logic              wr_q;
    logic              accept;
    logic              shift_en;
    logic              busy;
    logic              a_bit;
    logic              d_bit;
    logic [CNT_W-1:0]  a_cnt;
    logic [CNT_W-1:0]  d_cnt;
    logic              d_load;
    logic              d_shift;
    logic [DATA_W-1:0] d_din;
    logic [CNT_W-1:0]  shift_last;

    assign accept   = (state == ST_IDLE) && cmd_valid;
    // The handshake cycle in REQ shifts bit 0 out, SHIFT covers bits 1..L-1.
    assign shift_en = ((state == ST_REQ) && slave_ready) || (state == ST_SHIFT);
    assign busy     = (state == ST_REQ) || (state == ST_SHIFT);

`ifdef MASTER_OUT_BURST_EN
    localparam int LEN_W = BURST_W - 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);

    logic               burst_q;
    logic [LEN_W-1:0]   rem;
    logic               b_bit;
    logic [CNT_W-1:0]   b_cnt_unused;
    logic [BURST_W-1:0] bw;
    logic               beat_take;

    assign bw         = (cmd_len > LEN_W'(1)) ? {cmd_len, 1'b1} : '0;
    assign beat_take  = (state == ST_GAP) && wdata_valid;
    assign d_load     = accept || beat_take;
    assign d_din      = (beat_take || cmd_wr) ? wdata : '0;
    assign d_shift    = shift_en || (state == ST_BEAT);
    assign shift_last = burst_q ? BURST_LAST : ADDR_LAST;

    bus_piso #(.W(BURST_W), .CW(CNT_W)) u_burst_piso (
        .clk(clk), .reset(reset), .load(accept), .shift(shift_en),
        .din(bw), .dout(b_bit), .count(b_cnt_unused)
    );
`else
    assign d_load     = accept;
    assign d_din      = cmd_wr ? wdata : '0;
    assign d_shift    = shift_en;
    assign shift_last = ADDR_LAST;

    // Burst controls have no function in this build.
    wire unused_burst = ^{cmd_len, wdata_valid, d_cnt};
`endif

    bus_piso #(.W(ADDR_W), .CW(CNT_W)) u_addr_piso (
        .clk(clk), .reset(reset), .load(accept), .shift(shift_en),
        .din(cmd_addr), .dout(a_bit), .count(a_cnt)
    );

    bus_piso #(.W(DATA_W), .CW(CNT_W)) u_data_piso (
        .clk(clk), .reset(reset), .load(d_load), .shift(d_shift),
        .din(d_din), .dout(d_bit), .count(d_cnt)
    );

    // Transaction sequencer: accept, slave handshake, shift, optional beats, done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            wr_q  <= 1'b0;
`ifdef MASTER_OUT_BURST_EN
            burst_q <= 1'b0;
            rem     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state <= ST_REQ;
                        wr_q  <= cmd_wr;
`ifdef MASTER_OUT_BURST_EN
                        burst_q <= (cmd_len > LEN_W'(1));
                        // Beats after the first one; reads never carry beats.
                        rem <= (cmd_wr && (cmd_len > LEN_W'(1))) ? cmd_len - LEN_W'(1) : '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (slave_ready) state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (a_cnt == shift_last) begin
`ifdef MASTER_OUT_BURST_EN
                        state <= (rem != '0) ? ST_GAP : ST_DONE;
`else
                        state <= ST_DONE;
`endif
                    end
                end
`ifdef MASTER_OUT_BURST_EN
                ST_GAP: begin
                    if (wdata_valid) state <= ST_BEAT;
                end
                ST_BEAT: begin
                    if (d_cnt == DATA_LAST) begin
                        rem   <= rem - LEN_W'(1);
                        state <= (rem == LEN_W'(1)) ? ST_DONE : ST_GAP;
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output decode from state and shift-register heads; lines idle at 0.
    always_comb begin
        cmd_ready    = (state == ST_IDLE);
        master_valid = busy;
        write_en     = busy && wr_q;
        read_en      = busy && !wr_q;
        tx_address   = busy && a_bit;
        tx_done      = (state == ST_DONE);
`ifdef MASTER_OUT_BURST_EN
        tx_data      = (busy && wr_q && d_bit) || ((state == ST_BEAT) && d_bit);
        tx_burst     = busy && b_bit;
        wdata_ready  = (state == ST_GAP);
`else
        tx_data      = busy && wr_q && d_bit;
        tx_burst     = 1'b0;
        wdata_ready  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_master_out_port.sv
// Directed bench for master_out_port: single writes/reads, slave stall,
// back-to-back commands, ignored commands while busy, mid-transfer reset,
// and burst behaviour for whichever build is compiled.
module tb_master_out_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_addr;
    logic        cmd_wr;
    logic [11:0] cmd_len;
    logic [7:0]  wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic        slave_ready;
    logic        master_valid, read_en, write_en;
    logic        tx_address, tx_data, tx_burst, tx_done;

    int checks = 0;
    int failures = 0;

    master_out_port dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wr(cmd_wr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .slave_ready(slave_ready),
        .master_valid(master_valid), .read_en(read_en), .write_en(write_en),
        .tx_address(tx_address), .tx_data(tx_data), .tx_burst(tx_burst),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    function automatic logic [8:0] outs();
        return {cmd_ready, wdata_ready, master_valid, read_en, write_en,
                tx_address, tx_data, tx_burst, tx_done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command from IDLE and record the serial lines by bit index k
    // (k = 0 is the handshake cycle, slave_ready held low for sr_delay cycles).
    task automatic transact(input logic [11:0] addr, input logic wr, input logic [7:0] data,
                            input logic [11:0] len, input int sr_delay, input int pulse_k,
                            output logic [15:0] a_s, output logic [15:0] d_s,
                            output logic [15:0] b_s, output int done_t, output int mv_n,
                            output int rd_n, output int wr_n, output int done_n,
                            output int wrdy_n, output logic ready_end,
                            output logic ready_pulse);
        int k;
        a_s = '0; d_s = '0; b_s = '0;
        done_t = -1; mv_n = 0; rd_n = 0; wr_n = 0; done_n = 0; wrdy_n = 0;
        ready_end = 1'bx; ready_pulse = 1'bx;
        cmd_addr = addr; cmd_wr = wr; wdata = data; cmd_len = len;
        cmd_valid = 1'b1; slave_ready = 1'b0;
        for (int t = 1; t <= 60; t++) begin
            step();
            k = t - 1 - sr_delay;
            cmd_valid = 1'b0;
            if (k == 0) slave_ready = 1'b1;
            else if (k > 0) slave_ready = (t % 2 == 1);
            else slave_ready = 1'b0;
            if (k == pulse_k) begin
                cmd_valid   = 1'b1;
                cmd_addr    = 12'hFFF;
                ready_pulse = cmd_ready;
            end
            if (k >= 0 && k < 16) begin
                a_s[k] = tx_address;
                d_s[k] = tx_data;
                b_s[k] = tx_burst;
            end
            if (master_valid) mv_n++;
            if (read_en) rd_n++;
            if (write_en) wr_n++;
            if (wdata_ready) wrdy_n++;
            if (tx_done) begin
                done_n++;
                if (done_t < 0) done_t = t;
            end
            if (done_t >= 0 && t == done_t + 1) begin
                ready_end = cmd_ready;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    logic [15:0] a_s, d_s, b_s;
    int          done_t, mv_n, rd_n, wr_n, done_n, wrdy_n, extra;
    logic        ready_end, ready_pulse;
`ifdef MASTER_OUT_BURST_EN
    logic [12:0] a13, d13, b13;
    logic [7:0]  beat;
    int          gap_ok;
`endif

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wr = 1'b0; cmd_len = '0;
        wdata = '0; wdata_valid = 1'b0; slave_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'h100);
        reset = 1'b0;
        step();
        chk("idle_outs", 32'(outs()), 32'h100);

        // Single write 0xA5C / 0x3C, slave ready immediately.
        transact(12'hA5C, 1'b1, 8'h3C, 12'd1, 0, -100, a_s, d_s, b_s, done_t,
                 mv_n, rd_n, wr_n, done_n, wrdy_n, ready_end, ready_pulse);
        chk("wr1_addr_stream", 32'(a_s), 32'h0A5C);
        chk("wr1_data_stream", 32'(d_s), 32'h003C);
        chk("wr1_burst_stream", 32'(b_s), 32'h0000);
        chk("wr1_done_cycle", done_t, 13);
        chk("wr1_done_pulses", done_n, 1);
        chk("wr1_valid_cycles", mv_n, 12);
        chk("wr1_write_en_cycles", wr_n, 12);
        chk("wr1_read_en_cycles", rd_n, 0);
        chk("wr1_ready_after", 32'(ready_end), 32'h1);

        // Back-to-back read 0x001 with slave_ready low for 5 cycles.
        transact(12'h001, 1'b0, 8'hFF, 12'd0, 5, -100, a_s, d_s, b_s, done_t,
                 mv_n, rd_n, wr_n, done_n, wrdy_n, ready_end, ready_pulse);
        chk("rd_addr_stream", 32'(a_s), 32'h0001);
        chk("rd_data_zero", 32'(d_s), 32'h0000);
        chk("rd_done_cycle", done_t, 18);
        chk("rd_valid_cycles", mv_n, 17);
        chk("rd_read_en_cycles", rd_n, 17);
        chk("rd_write_en_cycles", wr_n, 0);

        // All-ones write: fields must not spill past their lengths.
        transact(12'hFFF, 1'b1, 8'hFF, 12'd0, 0, -100, a_s, d_s, b_s, done_t,
                 mv_n, rd_n, wr_n, done_n, wrdy_n, ready_end, ready_pulse);
        chk("ones_addr_stream", 32'(a_s), 32'h0FFF);
        chk("ones_data_stream", 32'(d_s), 32'h00FF);
        chk("ones_done_cycle", done_t, 13);

        // Command pulsed mid-shift must be ignored.
        transact(12'h123, 1'b1, 8'h81, 12'd1, 0, 6, a_s, d_s, b_s, done_t,
                 mv_n, rd_n, wr_n, done_n, wrdy_n, ready_end, ready_pulse);
        chk("busy_cmd_ready", 32'(ready_pulse), 32'h0);
        chk("busy_addr_stream", 32'(a_s), 32'h0123);
        chk("busy_data_stream", 32'(d_s), 32'h0081);
        chk("busy_done_pulses", done_n, 1);
        extra = 0;
        repeat (15) begin
            step();
            if (master_valid || tx_done) extra++;
        end
        chk("busy_no_second_txn", extra, 0);

        // Reset asserted while shifting bit 6.
        cmd_addr = 12'h3C3; cmd_wr = 1'b1; wdata = 8'hAA; cmd_len = 12'd1;
        cmd_valid = 1'b1; slave_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (6) step();
        chk("mid_valid_before_reset", 32'(master_valid), 32'h1);
        #2 reset = 1'b1;
        #1 chk("mid_reset_outs", 32'(outs()), 32'h100);
        #2 reset = 1'b0;
        step();
        transact(12'h5A5, 1'b1, 8'hC3, 12'd1, 0, -100, a_s, d_s, b_s, done_t,
                 mv_n, rd_n, wr_n, done_n, wrdy_n, ready_end, ready_pulse);
        chk("post_reset_addr", 32'(a_s), 32'h05A5);
        chk("post_reset_data", 32'(d_s), 32'h00C3);
        chk("post_reset_done", done_t, 13);

`ifndef MASTER_OUT_BURST_EN
        // Without burst support a length of 3 is still a single transfer.
        transact(12'h100, 1'b1, 8'h11, 12'd3, 0, -100, a_s, d_s, b_s, done_t,
                 mv_n, rd_n, wr_n, done_n, wrdy_n, ready_end, ready_pulse);
        chk("nob_burst_stream", 32'(b_s), 32'h0000);
        chk("nob_done_cycle", done_t, 13);
        chk("nob_wdata_ready", wrdy_n, 0);
`else
        // Read burst N=3: burst word only, no beats.
        transact(12'h0F0, 1'b0, 8'h00, 12'd3, 0, -100, a_s, d_s, b_s, done_t,
                 mv_n, rd_n, wr_n, done_n, wrdy_n, ready_end, ready_pulse);
        chk("rdb_burst_stream", 32'(b_s), 32'h0007);
        chk("rdb_done_cycle", done_t, 14);
        chk("rdb_wdata_ready", wrdy_n, 0);

        // Write burst 0x100, N=3, bytes 0x11/0x22/0x33, 4-cycle stall in first GAP.
        cmd_addr = 12'h100; cmd_wr = 1'b1; wdata = 8'h11; cmd_len = 12'd3;
        cmd_valid = 1'b1; slave_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 13; k++) begin
            a13[k] = tx_address; d13[k] = tx_data; b13[k] = tx_burst;
            step();
        end
        chk("wb_addr_stream", 32'(a13), 32'h0100);
        chk("wb_data_stream", 32'(d13), 32'h0011);
        chk("wb_burst_stream", 32'(b13), 32'h0007);
        gap_ok = 0;
        for (int i = 0; i < 4; i++) begin
            if (wdata_ready && !tx_data && !tx_done) gap_ok++;
            if (i == 3) begin
                wdata_valid = 1'b1;
                wdata = 8'h22;
            end
            step();
        end
        wdata_valid = 1'b0;
        chk("wb_gap_stall", gap_ok, 4);
        for (int j = 0; j < 8; j++) begin
            beat[j] = tx_data;
            step();
        end
        chk("wb_beat2", 32'(beat), 32'h22);
        chk("wb_gap2_ready", 32'(wdata_ready), 32'h1);
        wdata_valid = 1'b1; wdata = 8'h33;
        step();
        wdata_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            beat[j] = tx_data;
            step();
        end
        chk("wb_beat3", 32'(beat), 32'h33);
        chk("wb_done", 32'(tx_done), 32'h1);
        step();
        chk("wb_idle_after", 32'(outs()), 32'h100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
